ivector_requester: RTL and testbench

//  Initiator/checker for the indexed-vector say/heard protocol. Issues say(meth,v) requests

---
 rtl/ivector_requester_if.sv | 31 +++
 rtl/ivector_requester.sv | 175 +++++++++++++++++
 tb/tb_ivector_requester.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ivector_requester_if.sv
// Signal bundle between the say/heard requester (master) and the vector block / test harness
// (slave).
interface ivector_requester_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) ();
    logic                  start_ena;
    logic [CNT_WIDTH-1:0]  start_count;
    logic                  start_rdy;
    logic                  say_ena;
    logic [DATA_WIDTH-1:0] say_meth;
    logic [DATA_WIDTH-1:0] say_v;
    logic                  say_rdy;
    logic                  heard_ena;
    logic [DATA_WIDTH-1:0] heard_meth;
    logic [DATA_WIDTH-1:0] heard_v;
    logic                  heard_rdy;
    logic                  done_ena;
    logic [CNT_WIDTH-1:0]  rsp_count;
    logic [CNT_WIDTH-1:0]  err_count;

    modport master (
        input  start_ena, start_count, say_rdy, heard_ena, heard_meth, heard_v,
        output start_rdy, say_ena, say_meth, say_v, heard_rdy, done_ena, rsp_count, err_count
    );

    modport slave (
        output start_ena, start_count, say_rdy, heard_ena, heard_meth, heard_v,
        input  start_rdy, say_ena, say_meth, say_v, heard_rdy, done_ena, rsp_count, err_count
    );
endinterface

// File: rtl/ivector_requester.sv
// Round-robin say() traffic source with per-channel outstanding limit and in-order heard()
// data checking; counts responses and errors per run.
module ivector_requester #(
    parameter int unsigned NCHAN      = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUT    = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ivector_requester_if.master io_bus
);
    localparam int unsigned IdxW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned OutW = $clog2(MAX_OUT + 1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [IdxW-1:0]      LastCh = IdxW'(NCHAN - 1);
    localparam logic [OutW-1:0]      OutMax = OutW'(MAX_OUT);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_seq;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_rsp;
    logic [CNT_WIDTH-1:0]  r_err;
    logic [IdxW-1:0]       r_rr;
    logic [OutW-1:0]       r_out    [NCHAN];
    logic [DATA_WIDTH-1:0] r_expect [NCHAN];
    logic                  r_say_ena;
    logic                  r_done;
    logic                  r_heard_rdy;

    state_t                w_state_d;
    logic [IdxW-1:0]       w_rr_d;
    logic [OutW-1:0]       w_out_d  [NCHAN];
    logic [IdxW-1:0]       w_hm;
    logic                  w_start;
    logic                  w_xfer;
    logic                  w_heard;
    logic                  w_in_range;
    logic                  w_solicited;
    logic                  w_mismatch;
    logic                  w_rsp_ok;
    logic                  w_err_inc;
    logic                  w_last;
    logic                  w_all_idle;

    always_comb begin
        w_start    = (r_state == StIdle) && io_bus.start_ena;
        w_xfer     = r_say_ena && io_bus.say_rdy;
        w_heard    = io_bus.heard_ena && r_heard_rdy;
        w_in_range = io_bus.heard_meth < DATA_WIDTH'(NCHAN);
        w_hm       = io_bus.heard_meth[IdxW-1:0];

        // Only look up per-channel state once the channel number is known to be valid.
        w_solicited = 1'b0;
        w_mismatch  = 1'b0;
        if (w_in_range) begin
            w_solicited = (r_out[w_hm] != '0);
            w_mismatch  = (io_bus.heard_v != r_expect[w_hm]);
        end
        w_rsp_ok  = w_heard && w_solicited;
        w_err_inc = w_heard && (!w_solicited || w_mismatch);

        w_last     = (r_seq == (r_count - CNT_WIDTH'(1)));
        w_all_idle = 1'b1;
        for (int c = 0; c < NCHAN; c++) begin
            if (r_out[c] != '0) begin
                w_all_idle = 1'b0;
            end
        end

        // A say and a heard on the same channel in one cycle cancel out.
        for (int c = 0; c < NCHAN; c++) begin
            w_out_d[c] = r_out[c]
                       + OutW'(w_xfer && (r_rr == IdxW'(c)))
                       - OutW'(w_rsp_ok && (w_hm == IdxW'(c)));
        end

        w_rr_d = r_rr;
        if (w_start) begin
            w_rr_d = '0;
        end else if (w_xfer) begin
            w_rr_d = (r_rr == LastCh) ? '0 : r_rr + 1'b1;
        end

        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start && (io_bus.start_count != '0)) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (w_xfer && w_last) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_all_idle) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_seq       <= '0;
            r_count     <= '0;
            r_rsp       <= '0;
            r_err       <= '0;
            r_rr        <= '0;
            r_say_ena   <= 1'b0;
            r_done      <= 1'b0;
            r_heard_rdy <= 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                r_out[c]    <= '0;
                r_expect[c] <= DATA_WIDTH'(c);
            end
        end else begin
            r_heard_rdy <= 1'b1;
            r_state     <= w_state_d;
            r_rr        <= w_rr_d;
            for (int c = 0; c < NCHAN; c++) begin
                r_out[c] <= w_out_d[c];
            end
            // Strict round-robin: a full channel stalls the whole stream rather than being skipped.
            r_say_ena <= (w_state_d == StIssue) && (w_out_d[w_rr_d] < OutMax);
            r_done    <= (w_start && (io_bus.start_count == '0))
                      || ((r_state == StDrain) && w_all_idle);

            if (w_start) begin
                r_count <= io_bus.start_count;
                r_seq   <= '0;
                r_rsp   <= '0;
                r_err   <= '0;
                for (int c = 0; c < NCHAN; c++) begin
                    r_expect[c] <= DATA_WIDTH'(c);
                end
            end else begin
                if (w_xfer) begin
                    r_seq <= r_seq + 1'b1;
                end
                if (w_rsp_ok) begin
                    r_rsp          <= r_rsp + 1'b1;
                    r_expect[w_hm] <= r_expect[w_hm] + DATA_WIDTH'(NCHAN);
                end
                if (w_err_inc && (r_err != CntMax)) begin
                    r_err <= r_err + 1'b1;
                end
            end
        end
    end

    assign io_bus.start_rdy = (r_state == StIdle);
    assign io_bus.say_ena   = r_say_ena;
    assign io_bus.say_meth  = DATA_WIDTH'(r_rr);
    assign io_bus.say_v     = DATA_WIDTH'(r_seq);
    assign io_bus.heard_rdy = r_heard_rdy;
    assign io_bus.done_ena  = r_done;
    assign io_bus.rsp_count = r_rsp;
    assign io_bus.err_count = r_err;

    // A back-pressured request must keep its channel and payload.
    a_say_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_say_ena && !io_bus.say_rdy) |=> ($stable(r_rr) && $stable(r_seq)));

    for (genvar g = 0; g < NCHAN; g++) begin : g_out_chk
        a_out_bound: assert property (@(posedge i_clk) disable iff (i_rst)
            r_out[g] <= OutMax);
    end
endmodule

// File: tb/tb_ivector_requester.sv
// Randomized bench for ivector_requester: plays the vector block (loopback responder) and
// predicts every output from per-channel transaction counts.
module tb_ivector_requester;
    localparam int NCHAN      = 10;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_OUT    = 4;
    localparam int CNT_WIDTH  = 16;

    typedef enum int {MIdle, MIssue, MDrain} mphase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ivector_requester_if #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    ivector_requester #(
        .NCHAN      (NCHAN),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_OUT    (MAX_OUT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: run phase, says issued, per-channel in-flight and received counts.
    mphase_t m_phase = MIdle;
    int m_seq   = 0;
    int m_count = 0;
    int m_rsp   = 0;
    int m_err   = 0;
    int m_out  [NCHAN];
    int m_recv [NCHAN];
    bit m_done_exp = 1'b0;
    int n_xfer = 0;
    int n_done = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void bump_err();
        if (m_err != (1 << CNT_WIDTH) - 1) m_err++;
    endfunction

    function automatic void model_clear();
        m_phase = MIdle;
        m_seq = 0; m_count = 0; m_rsp = 0; m_err = 0;
        m_done_exp = 1'b0;
        for (int c = 0; c < NCHAN; c++) begin
            m_out[c]  = 0;
            m_recv[c] = 0;
        end
    endfunction

    task automatic drive_idle();
        bus.start_ena   = 1'b0;
        bus.start_count = '0;
        bus.say_rdy     = 1'b0;
        bus.heard_ena   = 1'b0;
        bus.heard_meth  = '0;
        bus.heard_v     = '0;
    endtask

    // Called at a negedge: drive inputs, check outputs, predict the coming posedge.
    task automatic cycle(input bit st, input int st_cnt, input bit srdy,
                         input bit h_en, input int h_meth, input int h_v);
        bit exp_ena, xfer, start_acc, all_empty;
        int ch;
        bus.start_ena   = st;
        bus.start_count = CNT_WIDTH'(st_cnt);
        bus.say_rdy     = srdy;
        bus.heard_ena   = h_en;
        bus.heard_meth  = DATA_WIDTH'(h_meth);
        bus.heard_v     = DATA_WIDTH'(h_v);

        ch      = m_seq % NCHAN;
        exp_ena = (m_phase == MIssue) && (m_out[ch] < MAX_OUT);
        check_eq("say_ena", bus.say_ena, exp_ena);
        if (exp_ena) begin
            check_eq("say_meth", bus.say_meth, ch);
            check_eq("say_v", bus.say_v, m_seq);
        end
        check_eq("start_rdy", bus.start_rdy, m_phase == MIdle);
        check_eq("done_ena", bus.done_ena, m_done_exp);
        check_eq("heard_rdy", bus.heard_rdy, 1);
        check_eq("rsp_count", bus.rsp_count, m_rsp);
        check_eq("err_count", bus.err_count, m_err);
        if (bus.say_ena && srdy) n_xfer++;
        if (bus.done_ena) n_done++;

        xfer      = exp_ena && srdy;
        start_acc = (m_phase == MIdle) && st;
        all_empty = 1'b1;
        foreach (m_out[i]) if (m_out[i] != 0) all_empty = 1'b0;

        if (h_en) begin
            if (h_meth < 0 || h_meth >= NCHAN) bump_err();
            else if (m_out[h_meth] == 0) bump_err();
            else begin
                m_out[h_meth]--;
                m_rsp++;
                if (h_v != h_meth + NCHAN * m_recv[h_meth]) bump_err();
                m_recv[h_meth]++;
            end
        end
        m_done_exp = (start_acc && st_cnt == 0) || (m_phase == MDrain && all_empty);
        if (xfer) begin
            m_out[ch]++;
            m_seq++;
            if (m_seq == m_count) m_phase = MDrain;
        end else if (m_phase == MDrain && all_empty) begin
            m_phase = MIdle;
        end
        if (start_acc) begin
            m_count = st_cnt; m_seq = 0; m_rsp = 0; m_err = 0;
            foreach (m_recv[i]) m_recv[i] = 0;
            if (st_cnt > 0) m_phase = MIssue;
        end
        @(negedge clk);
    endtask

    task automatic gen_heard(input int p_heard, input int p_inj,
                             output bit en, output int meth, output int v);
        int r, base, c;
        en = 1'b0; meth = 0; v = 0;
        r = $urandom_range(99);
        if (r < p_inj) begin
            en = 1'b1;
            if ($urandom_range(1) == 0) meth = NCHAN + $urandom_range(40);
            else meth = $urandom_range(NCHAN - 1);
            v = $urandom;
        end else if (r < p_inj + p_heard) begin
            base = $urandom_range(NCHAN - 1);
            for (int i = 0; i < NCHAN; i++) begin
                c = (base + i) % NCHAN;
                if (!en && m_out[c] > 0) begin
                    en = 1'b1; meth = c; v = c + NCHAN * m_recv[c];
                end
            end
        end
    endtask

    task automatic tick(input bit st, input int st_cnt, input int p_rdy,
                        input int p_heard, input int p_inj);
        bit h_en;
        int h_meth, h_v;
        gen_heard(p_heard, p_inj, h_en, h_meth, h_v);
        cycle(st, st_cnt, $urandom_range(99) < p_rdy, h_en, h_meth, h_v);
    endtask

    task automatic start_run(input int cnt, input int p_rdy);
        n_xfer = 0;
        n_done = 0;
        tick(1'b1, cnt, p_rdy, 0, 0);
    endtask

    task automatic finish_run(input string tag, input int p_rdy, input int p_heard,
                              input int p_inj, input int p_noise);
        int cyc;
        bit st;
        cyc = 0;
        while ((m_phase != MIdle || m_done_exp) && cyc < 4000) begin
            st = (m_phase != MIdle) && ($urandom_range(99) < p_noise);
            tick(st, $urandom_range(1, 30), p_rdy, p_heard, p_inj);
            cyc++;
        end
        check_eq({tag, "_finished"}, cyc < 4000, 1);
        check_eq({tag, "_done_pulses"}, n_done, 1);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        drive_idle();
        repeat (ncyc) @(negedge clk);
        check_eq("rst_heard_rdy", bus.heard_rdy, 0);
        check_eq("rst_say_ena", bus.say_ena, 0);
        check_eq("rst_done", bus.done_ena, 0);
        check_eq("rst_start_rdy", bus.start_rdy, 1);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("rst_rsp", bus.rsp_count, 0);
        check_eq("rst_err", bus.err_count, 0);
    endtask

    initial begin
        int guard, cnt, p_rdy, p_heard, p_inj;
        model_clear();
        drive_idle();
        do_reset(2);

        // Loopback, immediate drain.
        start_run(20, 100);
        finish_run("t1", 100, 100, 0, 0);
        check_eq("t1_xfers", n_xfer, 20);
        check_eq("t1_rsp", bus.rsp_count, 20);
        check_eq("t1_err", bus.err_count, 0);

        // Responses withheld: stream stops at the outstanding limit.
        start_run(50, 100);
        for (int i = 0; i < 60; i++) tick(1'b0, 0, 100, 0, 0);
        check_eq("t2_xfers", n_xfer, 40);
        check_eq("t2_ena", bus.say_ena, 0);
        check_eq("t2_meth", bus.say_meth, 0);
        check_eq("t2_v", bus.say_v, 40);
        finish_run("t2", 100, 60, 0, 0);
        check_eq("t2_total", n_xfer, 50);
        check_eq("t2_rsp", bus.rsp_count, 50);
        check_eq("t2_err", bus.err_count, 0);

        // Back-pressure held for 5 cycles at seq 7.
        start_run(30, 100);
        guard = 0;
        while (m_seq != 7 && guard < 100) begin tick(1'b0, 0, 100, 100, 0); guard++; end
        check_eq("t3_reach", guard < 100, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 0, 0, 100, 0);
            check_eq("t3_hold_ena", bus.say_ena, 1);
            check_eq("t3_hold_meth", bus.say_meth, 7);
            check_eq("t3_hold_v", bus.say_v, 7);
        end
        finish_run("t3", 100, 100, 0, 0);
        check_eq("t3_xfers", n_xfer, 30);
        check_eq("t3_rsp", bus.rsp_count, 30);

        // Corrupt data on channel 3, then an out-of-range channel.
        start_run(20, 100);
        guard = 0;
        while (m_seq < 5 && guard < 100) begin tick(1'b0, 0, 100, 0, 0); guard++; end
        cycle(1'b0, 0, 1'b1, 1'b1, 3, 99);
        check_eq("t4_err1", bus.err_count, 1);
        check_eq("t4_rsp1", bus.rsp_count, 1);
        cycle(1'b0, 0, 1'b1, 1'b1, 12, 0);
        check_eq("t4_err2", bus.err_count, 2);
        check_eq("t4_rsp2", bus.rsp_count, 1);
        finish_run("t4", 100, 100, 0, 0);
        check_eq("t4_err_end", bus.err_count, 2);
        check_eq("t4_rsp_end", bus.rsp_count, 20);

        // Zero-length run, then starts issued while busy.
        start_run(0, 100);
        finish_run("t5", 100, 100, 0, 0);
        check_eq("t5_xfers", n_xfer, 0);
        start_run(25, 100);
        for (int i = 0; i < 5; i++) tick(1'b1, 3, 100, 50, 0);
        finish_run("t5b", 100, 80, 0, 30);
        check_eq("t5b_xfers", n_xfer, 25);

        // Reset mid-run.
        start_run(40, 100);
        guard = 0;
        while (m_seq != 13 && guard < 200) begin tick(1'b0, 0, 100, 70, 0); guard++; end
        check_eq("t6_reach", guard < 200, 1);
        n_done = 0;
        do_reset(1);
        for (int i = 0; i < 5; i++) tick(1'b0, 0, 100, 0, 0);
        check_eq("t6_no_done", n_done, 0);

        for (int k = 0; k < 8; k++) begin
            cnt     = $urandom_range(1, 80);
            p_rdy   = $urandom_range(40, 100);
            p_heard = $urandom_range(20, 90);
            p_inj   = $urandom_range(0, 8);
            start_run(cnt, p_rdy);
            finish_run("rnd", p_rdy, p_heard, p_inj, 15);
            check_eq("rnd_xfers", n_xfer, cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
